// File: rtl/adc_rr_arbiter_pkg.sv
// Shared types for the two-consumer converter arbiter: state encoding and consumer ids.
package adc_rr_arbiter_pkg;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/adc_rr_arbiter_if.sv
// Converter handshake (soc/eoc/x) plus the two consumer rfd/dav_ ports and the shared z bus.
interface adc_rr_arbiter_if #(
  parameter int W  = 8,
  parameter int CW = 8
);

  logic          soc;
  logic          eoc;
  logic [W-1:0]  x;
  logic          rfd_a;
  logic          dav_a_;
  logic          rfd_b;
  logic          dav_b_;
  logic [W-1:0]  z;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  // master is the arbiter; slave is the converter plus consumers around it
  modport master (
    output soc, dav_a_, dav_b_, z, cnt_a, cnt_b,
    input  eoc, x, rfd_a, rfd_b
  );

  modport slave (
    input  soc, dav_a_, dav_b_, z, cnt_a, cnt_b,
    output eoc, x, rfd_a, rfd_b
  );

endinterface

// File: rtl/adc_rr_arbiter_rr_pick2.sv
// Two-way round-robin pick: sole requester wins, a tie goes to whoever was not served last.
module rr_pick2
  import adc_rr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    gnt_id = ID_A;
    if (req == 2'b11)
      gnt_id = ~last;
    else if (req[ID_B])
      gnt_id = ID_B;
  end

endmodule

// File: rtl/adc_rr_arbiter.sv
// Shares one soc/eoc converter between consumers A and B; each result goes on z and only
// the granted consumer sees its dav_ strobe.
module adc_rr_arbiter
  import adc_rr_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_,
  adc_rr_arbiter_if.master  bus
);

  state_t state;
  logic   grant;
  logic   last;
  logic   pick_id;
  logic   pick_any;

  rr_pick2 u_pick (
    .req    ({bus.rfd_b, bus.rfd_a}),
    .last   (last),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Grant is latched in S_IDLE and held until the served consumer drops rfd,
  // so the other consumer's rfd has no influence for the rest of the cycle.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state      <= S_IDLE;
      grant      <= ID_A;
      last       <= ID_B;
      bus.soc    <= 1'b0;
      bus.dav_a_ <= 1'b1;
      bus.dav_b_ <= 1'b1;
      bus.z      <= '0;
      bus.cnt_a  <= '0;
      bus.cnt_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.eoc && pick_any) begin
            grant   <= pick_id;
            bus.soc <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (!bus.eoc) begin
            bus.soc <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.eoc) begin
            bus.z <= bus.x;
            if (grant == ID_A)
              bus.dav_a_ <= 1'b0;
            else
              bus.dav_b_ <= 1'b0;
            state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (grant == ID_A && !bus.rfd_a) begin
            bus.dav_a_ <= 1'b1;
            bus.cnt_a  <= bus.cnt_a + 1'b1;
            last       <= ID_A;
            state      <= S_IDLE;
          end else if (grant == ID_B && !bus.rfd_b) begin
            bus.dav_b_ <= 1'b1;
            bus.cnt_b  <= bus.cnt_b + 1'b1;
            last       <= ID_B;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_rr_arbiter.sv
// Directed bench for adc_rr_arbiter: a table of deliveries plus hand-written reset and wrap sequences,
// with a converter model that drops eoc 2 clk after soc rises and returns data 2 clk after soc falls.
module tb_adc_rr_arbiter;
  import adc_rr_arbiter_pkg::*;

  typedef struct {
    bit         req_a;
    bit         req_b;
    logic [7:0] x;
    bit         exp_id;
    logic [7:0] exp_z;
    bit         toggle;
  } vec_t;

  logic clock;
  logic reset_;
  int   checks = 0;
  int   errors = 0;
  int   soc_pulses = 0;
  logic soc_prev = 1'b0;
  logic [7:0] exp_cnt_a = 8'd0;
  logic [7:0] exp_cnt_b = 8'd0;
  logic [7:0] x_q[$];
  int   conv_st = 0;
  int   conv_cnt = 0;

  adc_rr_arbiter_if #(.W(8), .CW(8)) bus ();

  adc_rr_arbiter dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Converter model: reacts to soc and hands back the next queued sample.
  always @(negedge clock) begin
    if (reset_ !== 1'b1) begin
      conv_st  = 0;
      conv_cnt = 0;
      bus.eoc  = 1'b1;
    end else begin
      case (conv_st)
        0: if (bus.soc) begin conv_st = 1; conv_cnt = 1; end
        1: if (conv_cnt == 2) begin bus.eoc = 1'b0; conv_st = 2; end else conv_cnt++;
        2: if (!bus.soc) begin conv_st = 3; conv_cnt = 1; end
        3: if (conv_cnt == 2) begin
             if (x_q.size() > 0) bus.x = x_q.pop_front();
             bus.eoc = 1'b1;
             conv_st = 0;
           end else conv_cnt++;
        default: conv_st = 0;
      endcase
    end
  end

  // Invariants held over the whole run, plus soc pulse counting.
  always @(negedge clock) begin
    if (reset_ === 1'b1) begin
      checks++;
      if (bus.dav_a_ === 1'b0 && bus.dav_b_ === 1'b0) begin
        errors++;
        $display("[TB] FAIL both_dav: dav_a_=%b dav_b_=%b required not both 0", bus.dav_a_, bus.dav_b_);
      end
      checks++;
      if (bus.soc === 1'b1 && (bus.dav_a_ === 1'b0 || bus.dav_b_ === 1'b0)) begin
        errors++;
        $display("[TB] FAIL soc_with_dav: soc=%b dav_a_=%b dav_b_=%b", bus.soc, bus.dav_a_, bus.dav_b_);
      end
    end
    if (bus.soc === 1'b1 && soc_prev !== 1'b1) soc_pulses++;
    soc_prev = bus.soc;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One delivery: raise requests, wait for a dav_, check it, then let the consumer release it.
  task automatic applyStimulus(input vec_t v);
    bit         seen;
    bit         other_ok;
    bit         soc_seen;
    bit         got_id;
    logic [7:0] got_z;
    int         p0;
    seen     = 1'b0;
    other_ok = 1'b1;
    soc_seen = 1'b0;
    got_id   = 1'b0;
    got_z    = 8'h00;
    x_q.push_back(v.x);
    p0 = soc_pulses;
    bus.rfd_a = v.req_a;
    bus.rfd_b = v.req_b;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      if (bus.dav_a_ === 1'b0 || bus.dav_b_ === 1'b0) begin
        seen   = 1'b1;
        got_id = (bus.dav_a_ === 1'b0) ? ID_A : ID_B;
        got_z  = bus.z;
      end else begin
        if ((v.exp_id == ID_A ? bus.dav_b_ : bus.dav_a_) !== 1'b1) other_ok = 1'b0;
        if (bus.soc === 1'b1) soc_seen = 1'b1;
        if (v.toggle && soc_seen) begin
          if (v.exp_id == ID_A) bus.rfd_b = ~bus.rfd_b;
          else                  bus.rfd_a = ~bus.rfd_a;
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL dav_timeout: no dav_ within 60 clk, required consumer %0d", v.exp_id);
    end else begin
      checkOutput("grant_id", 32'(got_id), 32'(v.exp_id));
      checkOutput("z", 32'(got_z), 32'(v.exp_z));
      checkOutput("other_dav_idle", 32'(other_ok), 32'd1);
    end
    if (v.exp_id == ID_A) begin
      bus.rfd_a = 1'b0;
      if (v.toggle) bus.rfd_b = 1'b0;
      exp_cnt_a = exp_cnt_a + 8'd1;
    end else begin
      bus.rfd_b = 1'b0;
      if (v.toggle) bus.rfd_a = 1'b0;
      exp_cnt_b = exp_cnt_b + 8'd1;
    end
    @(negedge clock);
    checkOutput("dav_release", 32'({bus.dav_a_, bus.dav_b_}), 32'd3);
    checkOutput("cnt_a", 32'(bus.cnt_a), 32'(exp_cnt_a));
    checkOutput("cnt_b", 32'(bus.cnt_b), 32'(exp_cnt_b));
    checkOutput("soc_pulses", 32'(soc_pulses - p0), 32'd1);
  endtask

  vec_t tbl[8];
  vec_t v;
  int   p_before;
  bit   got;

  initial begin
    reset_    = 1'b0;
    bus.rfd_a = 1'b0;
    bus.rfd_b = 1'b0;
    bus.x     = 8'h00;

    //               a  b  x      id    z      toggle
    tbl[0] = '{1'b1, 1'b0, 8'h5A, ID_A, 8'h5A, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h77, ID_A, 8'h77, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'hC3, ID_B, 8'hC3, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h01, ID_A, 8'h01, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h02, ID_B, 8'h02, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h03, ID_A, 8'h03, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h04, ID_B, 8'h04, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'hE1, ID_B, 8'hE1, 1'b0};

    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    checkOutput("rst_soc", 32'(bus.soc), 32'd0);
    checkOutput("rst_dav_a", 32'(bus.dav_a_), 32'd1);
    checkOutput("rst_dav_b", 32'(bus.dav_b_), 32'd1);
    checkOutput("rst_z", 32'(bus.z), 32'd0);
    checkOutput("rst_cnt_a", 32'(bus.cnt_a), 32'd0);
    checkOutput("rst_cnt_b", 32'(bus.cnt_b), 32'd0);
    p_before = soc_pulses;
    repeat (20) @(negedge clock);
    checkOutput("idle_no_soc", 32'(soc_pulses - p_before), 32'd0);

    $display("[TB] table-driven deliveries");
    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

    $display("[TB] reset while presenting to A");
    x_q.push_back(8'h33);
    bus.rfd_a = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clock);
      if (bus.dav_a_ === 1'b0) got = 1'b1;
    end
    checkOutput("pre_reset_dav_a", 32'(got), 32'd1);
    reset_    = 1'b0;
    bus.rfd_a = 1'b0;
    @(negedge clock);
    checkOutput("midrst_dav_a", 32'(bus.dav_a_), 32'd1);
    checkOutput("midrst_soc", 32'(bus.soc), 32'd0);
    checkOutput("midrst_cnt_a", 32'(bus.cnt_a), 32'd0);
    checkOutput("midrst_z", 32'(bus.z), 32'd0);
    reset_    = 1'b1;
    exp_cnt_a = 8'd0;
    exp_cnt_b = 8'd0;
    v = '{1'b1, 1'b0, 8'h44, ID_A, 8'h44, 1'b0};
    applyStimulus(v);

    $display("[TB] 256 deliveries to B");
    for (int i = 0; i < 256; i++) begin
      v.req_a  = 1'b0;
      v.req_b  = 1'b1;
      v.x      = 8'(i);
      v.exp_id = ID_B;
      v.exp_z  = 8'(i);
      v.toggle = 1'b0;
      applyStimulus(v);
    end
    checkOutput("cnt_b_wrap", 32'(bus.cnt_b), 32'd0);
    checkOutput("cnt_a_after_wrap", 32'(bus.cnt_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
